// File: rtl/regfile_32x32_pkg.sv
// Register file shared constants.
// Widths and the hardwired-zero address used by decode/writeback.
package regfile_32x32_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

  localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_32x32.sv
// 32x32 register file: two combinational reads, one synchronous write.
// Register 0 always reads as zero and ignores writes.
module regfile_32x32
  import regfile_32x32_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wen_d;

  // Write qualifier: writes to the zero register are dropped.
  always_comb begin
    wen_d = we && (waddr != ZERO_A);
  end

  // Reset clears every entry and wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen_d) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == ZERO_A) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == ZERO_A) ? '0 : regs_q[raddr2];

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed bench for regfile_32x32.
// Expected read values are queued at drive time and popped at check time.
module tb_regfile_32x32;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];

  regfile_32x32 dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] e1, input logic [31:0] e2);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
  endtask

  task automatic check(input string tag);
    logic [31:0] e1;
    logic [31:0] e2;
    checks++;
    if (exp_q.size() < 2) begin
      errors++;
      $display("FAIL %s scoreboard empty got %0d want 2",
               tag, exp_q.size());
      return;
    end
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    assert (rdata1 === e1) else begin
      errors++;
      $error("FAIL %s rdata1 got %h want %h", tag, rdata1, e1);
    end
    checks++;
    assert (rdata2 === e2) else begin
      errors++;
      $error("FAIL %s rdata2 got %h want %h", tag, rdata2, e2);
    end
  endtask

  initial begin
    rst    = 1'b1;
    we     = 1'b1;
    waddr  = 5'd3;
    wdata  = 32'hFFFF_FFFF;
    raddr1 = 5'd3;
    raddr2 = 5'd12;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      tick();
      push(32'h0, 32'h0);
      check("rst_beats_wr");
    end

    rst = 1'b0;
    #1;
    push(32'h0, 32'h0);
    check("pre_wr3");
    tick();
    push(32'hFFFF_FFFF, 32'h0);
    check("post_wr3");

    waddr = 5'd6;
    wdata = 32'h0000_FFFF;
    tick();
    we    = 1'b0;
    waddr = 5'd9;
    wdata = 32'h1234_5678;
    tick();
    raddr1 = 5'd9;
    raddr2 = 5'd6;
    #1;
    push(32'h0, 32'h0000_FFFF);
    check("we0_hold");

    we    = 1'b1;
    wdata = 32'h0000_FFFF;
    tick();
    we     = 1'b0;
    raddr1 = 5'd6;
    raddr2 = 5'd6;
    #1;
    push(32'h0000_FFFF, 32'h0000_FFFF);
    check("same_addr6");
    raddr1 = 5'd9;
    raddr2 = 5'd3;
    #1;
    push(32'h0000_FFFF, 32'hFFFF_FFFF);
    check("r9_r3");

    waddr = 5'd3;
    wdata = 32'h0;
    tick();
    push(32'h0000_FFFF, 32'hFFFF_FFFF);
    check("we0_r3");

    we     = 1'b1;
    waddr  = 5'd6;
    wdata  = 32'h0;
    raddr1 = 5'd9;
    raddr2 = 5'd6;
    #1;
    push(32'h0000_FFFF, 32'h0000_FFFF);
    check("rdw_old");
    tick();
    push(32'h0000_FFFF, 32'h0);
    check("rdw_new");

    waddr  = 5'd0;
    wdata  = 32'hDEAD_BEEF;
    raddr1 = 5'd0;
    raddr2 = 5'd3;
    #1;
    push(32'h0, 32'hFFFF_FFFF);
    check("w0_pre");
    tick();
    push(32'h0, 32'hFFFF_FFFF);
    check("w0_ignored");

    waddr = 5'd31;
    wdata = 32'hA5A5_A5A5;
    tick();
    wdata = 32'h5A5A_5A5A;
    tick();
    we     = 1'b0;
    raddr1 = 5'd31;
    raddr2 = 5'd31;
    #1;
    push(32'h5A5A_5A5A, 32'h5A5A_5A5A);
    check("last_wins");

    rst   = 1'b1;
    we    = 1'b1;
    waddr = 5'd9;
    wdata = 32'hCAFE_F00D;
    raddr1 = 5'd3;
    raddr2 = 5'd9;
    #1;
    push(32'hFFFF_FFFF, 32'h0000_FFFF);
    check("pre_mid_rst");
    tick();
    rst = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      push(32'h0, 32'h0);
      check("post_mid_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
